cla_pipe_adder: RTL
===================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor, the successor to our fixed 16-bit combinational CLA. Operands of WIDTH bits are split into 16-bit slices. Each slice is a 4×4-bit two-level CLA, and one pipeline stage is spent per slice, with the inter-slice carry registered. A valid/ready handshake on both sides gives one operation per cycle of throughput and full backpressure. It sits in the datapath wherever adds wider than 16 bits must meet timing.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of 16, minimum 16.
- L (localparam), WIDTH/16: number of slices = pipeline depth = latency.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- carry_in  in  1  carry into bit 0 (add mode only).
- sub  in  1  1 = A − B; 0 = A + B + carry_in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry_out  out  1  carry out of bit WIDTH−1.
- ovf  out  1  signed overflow (see Configuration).
- zero  out  1  sum == 0 (see Configuration).

## Operation
- Reset values: in_ready 1, out_valid 0, sum 0, carry_out 0, ovf 0, zero 0; all stage valids and skew registers 0.
- Subtract: the effective B is ~B and the effective carry is 1; carry_in is ignored. carry_out = 1 means no borrow (A ≥ B unsigned).
- Stage k (0..L−1) adds slice k of A and effective-B plus the carry registered by stage k−1. Stage 0 uses the effective carry.
- Upper operand slices are skewed forward through delay registers. Lower result slices are de-skewed, so the full sum, carry_out and flags appear aligned on one output beat.
- Stall rule: advance = !out_valid || out_ready. in_ready = advance. When advance = 0, every stage register, including valids, holds.
- Bubbles propagate: a stage with valid 0 still shifts when advance = 1.
- Within a slice, carries come from group generate/propagate (G = g3|p3g2|p3p2g1|p3p2p1g0, P = p3p2p1p0), not ripple.

## Timing
- Latency: an operation accepted at edge n appears with out_valid = 1 after edge n+L, assuming no stall.
- Throughput: 1 op/cycle while out_ready = 1.
- Outputs are registered and stable while out_valid && !out_ready. A held result must not change until accepted.
- in_ready is combinational from out_ready and out_valid. There is no combinational path from A, B or in_valid to any output.
- Simultaneous accept-in and drain-out in the same cycle is legal and loses no beat.
- Reset mid-operation: every in-flight op is discarded. out_valid drops asynchronously and stays 0 until a new op traverses the full L stages.
- WIDTH = 16 degenerates to a single registered stage with latency 1.

## Configuration
- CLA_PIPE_FLAGS_EN defined: ovf = carry into MSB XOR carry_out, computed on the effective operands. zero = (sum == 0). Both are registered with the final stage and aligned with sum.
- CLA_PIPE_FLAGS_EN undefined: the ovf and zero ports remain but are tied to 0. No flag logic is synthesised.

## Test plan
- WIDTH = 32, add 0xFFFFFFFF + 0x00000001, carry_in 0 -> sum 0x00000000, carry_out 1, out_valid exactly 2 cycles after accept. With flags: zero 1, ovf 0.
- sub, A = 5, B = 10 -> sum 0xFFFFFFFB, carry_out 0. Then A = 10, B = 5 -> sum 0x00000005, carry_out 1. carry_in = 1 has no effect in either case.
- Flags build: 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, ovf 1, carry_out 0. Non-flags build: ovf and zero stay 0.
- Back-to-back: 8 consecutive accepts (i + 1000·i for i = 0..7) with out_ready held 1 -> 8 consecutive output beats in order, sums 1001·i, no gaps.
- Backpressure: hold out_ready = 0 for 5 cycles with 3 ops in flight -> in_ready 0 once out_valid rises, the held sum stays stable, and release delivers all 3 ops in order with none lost or duplicated.
- Reset asserted with 2 ops in flight -> out_valid 0 immediately, no stale beat after release. A fresh op 0x0000FFFF + 0x00000001 -> 0x00010000, exercising the carry across the slice boundary.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, 16-bit 4x4 CLA slice per stage; CLA_PIPE_FLAGS_EN adds ovf/zero.
// Latency: WIDTH/16 cycles from accept to out_valid; one operation per cycle.
// Backpressure: the whole pipe freezes while a result is held (out_valid && !out_ready); in_ready follows.
module cla_pipe_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf,
    output logic             zero
);
    localparam int L = WIDTH / 16;

    // Two-level CLA: bit carries from in-group lookahead, group carries from group G/P.
    function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [15:0] g, p, c;
        logic [3:0]  gg, gp;
        logic [4:0]  gc;
        g = a & b;
        p = a ^ b;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = ci;
        gc[1] = gg[0] | (gp[0] & ci);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & ci);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {gc[4], p ^ c};
    endfunction

    logic             out_valid_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~B : B;
    assign c_eff    = sub | carry_in;

    // Stage k holds slice k onward of the operands (already-consumed slices dropped)
    // plus the finished lower result slices, so every bit that is stored is used.
    genvar k;
    for (k = 0; k < L; k++) begin : g_stg
        localparam int REM = WIDTH - 16*k;
        logic             v_cur;
        logic             c_cur;
        logic [REM-1:0]   a_cur;
        logic [REM-1:0]   b_cur;
        logic [16*k+15:0] s_acc;
        logic [16:0]      r;

        assign r = cla16(a_cur[15:0], b_cur[15:0], c_cur);

        if (k == 0) begin : g_in
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_cur <= 1'b0;
                    c_cur <= 1'b0;
                    a_cur <= '0;
                    b_cur <= '0;
                end else if (advance) begin
                    v_cur <= in_valid;
                    c_cur <= c_eff;
                    a_cur <= A;
                    b_cur <= b_eff;
                end
            end
            assign s_acc = r[15:0];
        end else begin : g_in
            logic [16*k-1:0] s_lo_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_cur  <= 1'b0;
                    c_cur  <= 1'b0;
                    a_cur  <= '0;
                    b_cur  <= '0;
                    s_lo_q <= '0;
                end else if (advance) begin
                    v_cur  <= g_stg[k-1].v_cur;
                    c_cur  <= g_stg[k-1].r[16];
                    a_cur  <= g_stg[k-1].a_cur[REM+15:16];
                    b_cur  <= g_stg[k-1].b_cur[REM+15:16];
                    s_lo_q <= g_stg[k-1].s_acc;
                end
            end
            assign s_acc = {r[15:0], s_lo_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
        end else if (advance) begin
            out_valid_q <= g_stg[L-1].v_cur;
            sum_q       <= g_stg[L-1].s_acc;
            carry_q     <= g_stg[L-1].r[16];
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_q;

`ifdef CLA_PIPE_FLAGS_EN
    logic ovf_q;
    logic zero_q;
    logic msb_cin;

    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
    assign msb_cin = g_stg[L-1].a_cur[15] ^ g_stg[L-1].b_cur[15] ^ g_stg[L-1].r[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            ovf_q  <= msb_cin ^ g_stg[L-1].r[16];
            zero_q <= ~|g_stg[L-1].s_acc;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule
